fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RV32I core. It owns the program counter and issues single-outstanding word requests to instruction memory. It discards wrong-path responses after a branch or jump redirect. It presents each fetched instruction and its PC to decode through a valid/ready handshake. Decode, including immediate generation, consumes `dec_instr` directly.

---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response, execute redirect
// and the decode valid/ready handshake.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// RV32I instruction-fetch sequencer: owns the PC, keeps one imem request in flight,
// squashes wrong-path responses after a redirect and buffers one word for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_dec_instr;
  logic [31:0] w_dec_instr_nxt;
  logic [31:0] r_dec_pc;
  logic [31:0] w_dec_pc_nxt;
  logic [31:0] w_redir_tgt;

  assign w_redir_tgt = {bus.redirect_pc[31:2], 2'b00};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, in-flight tag, kill flag and decode buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= 32'h0000_0000;
      r_kill      <= 1'b0;
      r_dec_instr <= NOP_INSTR;
      r_dec_pc    <= 32'h0000_0000;
    end else begin
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_kill      <= w_kill_nxt;
      r_dec_instr <= w_dec_instr_nxt;
      r_dec_pc    <= w_dec_pc_nxt;
    end
  end

  // Next-state and datapath update; a redirect overrides every other event
  always_comb begin
    w_state_nxt     = r_state;
    w_req_pc_nxt    = r_req_pc;
    w_kill_nxt      = r_kill;
    w_dec_instr_nxt = r_dec_instr;
    w_dec_pc_nxt    = r_dec_pc;
    if (bus.redirect_valid) begin
      w_pc_nxt = w_redir_tgt;
    end else begin
      w_pc_nxt = r_pc;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_gnt) begin
          w_state_nxt  = S_WAIT;
          w_req_pc_nxt = r_pc;
          if (bus.redirect_valid) begin
            w_kill_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        // A kill pending or arriving with the response turns it into a discard
        if (bus.imem_rvalid) begin
          if (r_kill || bus.redirect_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_dec_instr_nxt = bus.imem_rdata;
            w_dec_pc_nxt    = r_req_pc;
            w_state_nxt     = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          w_kill_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid || bus.dec_ready) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req  = (r_state == S_REQ);
  assign bus.imem_addr = r_pc;
  assign bus.dec_valid = (r_state == S_HOLD) & ~bus.redirect_valid;
  assign bus.dec_instr = r_dec_instr;
  assign bus.dec_pc    = r_dec_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level model of the fetch stream
// checked every cycle, directed scenarios with literal expectations, and a random soak.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus0();
  fetch_ctrl_if bus1();

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Second instance: always-granting zero-wait memory, decode always ready
  assign bus1.imem_gnt       = bus1.imem_req;
  assign bus1.redirect_valid = 1'b0;
  assign bus1.redirect_pc    = 32'h0000_0000;
  assign bus1.dec_ready      = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus1.imem_rvalid <= 1'b0;
      bus1.imem_rdata  <= 32'h0000_0000;
    end else begin
      bus1.imem_rvalid <= bus1.imem_req & bus1.imem_gnt;
      bus1.imem_rdata  <= word_of(bus1.imem_addr);
    end
  end

  // Memory model and stimulus knobs for dut0
  logic        mem_pend;
  logic [31:0] mem_addr;
  int unsigned mem_lat, lat_min, lat_max, gnt_pct, rdy_pct, redir_pct, gnt_deny;

  // Event logs written by the monitor
  logic [31:0] g_addr[$];
  int          g_cyc[$];
  logic [31:0] d_pc[$];
  logic [31:0] d_instr[$];
  logic [31:0] g1_addr[$];

  // Behavioural model: next program-order address, the one in-flight fetch, the decode buffer
  int          cyc;
  logic        m_out, m_out_live, m_buf, exp_req, exp_dv;
  logic [31:0] m_pc, m_out_addr, m_buf_pc;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; m_out = 1'b0; m_out_live = 1'b0; m_buf = 1'b0;
        m_pc = 32'h0000_0100; m_out_addr = 32'h0; m_buf_pc = 32'h0;
      end else begin
        exp_req = (cyc != 0) && !m_out && !m_buf;
        chk("imem_req", {31'd0, bus0.imem_req}, {31'd0, exp_req});
        if (bus0.imem_req) chk("imem_addr", bus0.imem_addr, m_pc);
        chk("addr_align", {30'd0, bus0.imem_addr[1:0]}, 32'd0);
        exp_dv = m_buf && !bus0.redirect_valid;
        chk("dec_valid", {31'd0, bus0.dec_valid}, {31'd0, exp_dv});
        if (exp_dv) begin
          chk("dec_pc", bus0.dec_pc, m_buf_pc);
          chk("dec_instr", bus0.dec_instr, word_of(m_buf_pc));
          if (bus0.dec_ready) begin
            d_pc.push_back(bus0.dec_pc);
            d_instr.push_back(bus0.dec_instr);
            m_buf = 1'b0;
          end
        end
        if (bus0.imem_rvalid && m_out) begin
          m_out = 1'b0;
          if (m_out_live && !bus0.redirect_valid) begin
            m_buf = 1'b1;
            m_buf_pc = m_out_addr;
          end
        end
        if (bus0.imem_req && bus0.imem_gnt) begin
          g_addr.push_back(bus0.imem_addr);
          g_cyc.push_back(cyc);
          m_out = 1'b1; m_out_live = 1'b1; m_out_addr = m_pc;
          m_pc = m_pc + 32'd4;
        end
        if (bus0.redirect_valid) begin
          m_pc = {bus0.redirect_pc[31:2], 2'b00};
          m_out_live = 1'b0;
          m_buf = 1'b0;
        end
        if (bus1.imem_req && bus1.imem_gnt) g1_addr.push_back(bus1.imem_addr);
        cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    bus0.imem_rvalid = 1'b0;
    if (mem_pend) begin
      if (mem_lat == 0) begin
        bus0.imem_rvalid = 1'b1;
        bus0.imem_rdata  = word_of(mem_addr);
        mem_pend = 1'b0;
      end else begin
        mem_lat = mem_lat - 1;
      end
    end
    bus0.imem_gnt = 1'b0;
    if (bus0.imem_req && !mem_pend && !bus0.imem_rvalid) begin
      if (gnt_deny > 0) gnt_deny = gnt_deny - 1;
      else if ($urandom_range(99) < gnt_pct) bus0.imem_gnt = 1'b1;
    end
    if (bus0.imem_gnt) begin
      mem_pend = 1'b1;
      mem_addr = bus0.imem_addr;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    bus0.dec_ready = ($urandom_range(99) < rdy_pct);
    bus0.redirect_valid = 1'b0;
    if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc = $urandom();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_pend = 1'b0; mem_addr = 32'h0; mem_lat = 0;
    lat_min = 0; lat_max = 0; gnt_pct = 100; rdy_pct = 100; redir_pct = 0; gnt_deny = 0;
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 32'h0;
    bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'h0; bus0.dec_ready = 1'b1;
    repeat (2) @(posedge clk);
    g_addr.delete(); g_cyc.delete(); d_pc.delete(); d_instr.delete(); g1_addr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_gnts(input int n);
    for (int i = 0; i < 40 && g_addr.size() < n; i++) step();
    chk("gnt_count", {31'd0, g_addr.size() >= n}, 32'd1);
  endtask

  task automatic wait_dlvs(input int n);
    for (int i = 0; i < 40 && d_pc.size() < n; i++) step();
    chk("dlv_count", {31'd0, d_pc.size() >= n}, 32'd1);
  endtask

  initial begin
    bit found;
    // Reset values and zero-wait streaming
    do_reset();
    chk("rst_req", {31'd0, bus0.imem_req}, 32'd0);
    chk("rst_dv", {31'd0, bus0.dec_valid}, 32'd0);
    chk("rst_addr", bus0.imem_addr, 32'h0000_0100);
    chk("rst_instr", bus0.dec_instr, 32'h0000_0013);
    chk("rst_dpc", bus0.dec_pc, 32'h0000_0000);
    repeat (10) step();
    wait_gnts(3);
    wait_dlvs(3);
    if (g_addr.size() >= 3 && d_pc.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t1_gcyc", g_cyc[k], 1 + 3 * k);
        chk("t1_gaddr", g_addr[k], 32'h0000_0100 + 32'(4 * k));
        chk("t1_dpc", d_pc[k], 32'h0000_0100 + 32'(4 * k));
        chk("t1_dinstr", d_instr[k], word_of(32'h0000_0100 + 32'(4 * k)));
      end
    end

    // Decode backpressure for 5 cycles in HOLD
    do_reset();
    rdy_pct = 0;
    for (int i = 0; i < 20 && !bus0.dec_valid; i++) step();
    for (int k = 0; k < 5; k++) begin
      chk("t2_dv", {31'd0, bus0.dec_valid}, 32'd1);
      chk("t2_dpc", bus0.dec_pc, 32'h0000_0100);
      chk("t2_instr", bus0.dec_instr, word_of(32'h0000_0100));
      chk("t2_req", {31'd0, bus0.imem_req}, 32'd0);
      step();
    end
    rdy_pct = 100;
    bus0.dec_ready = 1'b1;
    wait_gnts(2);
    if (g_addr.size() >= 2) chk("t2_next", g_addr[1], 32'h0000_0104);

    // Redirect during WAIT, killed response arrives 3 cycles later
    do_reset();
    lat_min = 3; lat_max = 3;
    step();
    lat_min = 0; lat_max = 0;
    step();
    chk("t3_inwait", {31'd0, bus0.imem_req}, 32'd0);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_2003;
    wait_gnts(2);
    if (g_addr.size() >= 2) chk("t3_tgt", g_addr[1], 32'h0000_2000);
    wait_dlvs(1);
    if (d_pc.size() >= 1) chk("t3_first_dlv", d_pc[0], 32'h0000_2000);

    // Redirect coincident with the grant of 0x108
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus0.imem_req && bus0.imem_gnt && (bus0.imem_addr == 32'h0000_0108);
    end
    chk("t4a_found", {31'd0, found}, 32'd1);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_3000;
    wait_gnts(4);
    wait_dlvs(3);
    if (g_addr.size() >= 4) chk("t4a_tgt", g_addr[3], 32'h0000_3000);
    if (d_pc.size() >= 3) chk("t4a_dlv", d_pc[2], 32'h0000_3000);

    // Redirect coincident with the response for 0x108
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus0.imem_rvalid && (mem_addr == 32'h0000_0108);
    end
    chk("t4b_found", {31'd0, found}, 32'd1);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_4000;
    wait_gnts(4);
    wait_dlvs(3);
    if (g_addr.size() >= 4) chk("t4b_tgt", g_addr[3], 32'h0000_4000);
    if (d_pc.size() >= 3) chk("t4b_dlv", d_pc[2], 32'h0000_4000);

    // Grant held off 4 cycles, redirect in the 2nd ungranted cycle
    do_reset();
    gnt_deny = 4;
    step();
    chk("t5_c1_req", {31'd0, bus0.imem_req}, 32'd1);
    chk("t5_c1_addr", bus0.imem_addr, 32'h0000_0100);
    step();
    chk("t5_c2_addr", bus0.imem_addr, 32'h0000_0100);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_5004;
    step();
    chk("t5_c3_req", {31'd0, bus0.imem_req}, 32'd1);
    chk("t5_c3_addr", bus0.imem_addr, 32'h0000_5004);
    wait_gnts(1);
    if (g_addr.size() >= 1) begin
      chk("t5_gaddr", g_addr[0], 32'h0000_5004);
      chk("t5_gcyc", g_cyc[0], 5);
    end

    // PC wrap on the second instance
    chk("t6_g1_count", {31'd0, g1_addr.size() >= 2}, 32'd1);
    if (g1_addr.size() >= 2) begin
      chk("t6_wrap0", g1_addr[0], 32'hFFFF_FFFC);
      chk("t6_wrap1", g1_addr[1], 32'h0000_0000);
    end

    // Asynchronous reset pulse mid-WAIT
    do_reset();
    wait_dlvs(2);
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus0.imem_gnt;
    end
    step();
    chk("t7_inwait", {31'd0, bus0.imem_req}, 32'd0);
    chk("t7_pre_instr", {31'd0, bus0.dec_instr != 32'h0000_0013}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_req", {31'd0, bus0.imem_req}, 32'd0);
    chk("t7_dv", {31'd0, bus0.dec_valid}, 32'd0);
    chk("t7_addr", bus0.imem_addr, 32'h0000_0100);
    chk("t7_instr", bus0.dec_instr, 32'h0000_0013);
    chk("t7_dpc", bus0.dec_pc, 32'h0000_0000);
    chk("t7_addr1", bus1.imem_addr, 32'hFFFF_FFFC);
    do_reset();
    wait_gnts(1);
    if (g_addr.size() >= 1) chk("t7_refetch", g_addr[0], 32'h0000_0100);

    // Random soak against the model
    do_reset();
    gnt_pct = 60; lat_min = 0; lat_max = 3; rdy_pct = 70; redir_pct = 8;
    repeat (3000) step();
    chk("rand_progress", {31'd0, d_pc.size() > 50}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
